dpwm_duty_sequencer: RTL

//   Sequences the 10-bit duty command for the dither + deadtime DPWM path.

---
 rtl/dpwm_pkg.sv | 38 +++
 rtl/dpwm_frame_tick.sv | 35 +++
 rtl/dpwm_duty_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/dpwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dpwm_pkg
// Purpose  : Shared types, state encodings and the saturating duty step used
//            by the DPWM duty sequencer.
// Revision : 1.0  initial release
// ============================================================================
package dpwm_pkg;

  // Duty command width shared by every file in this slice
  localparam int DUTY_W = 10;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_SOFTSTART = 3'd1;
  localparam state_t ST_RUN       = 3'd2;
  localparam state_t ST_SHUTDOWN  = 3'd3;
  localparam state_t ST_FAULT     = 3'd4;

  // Add or subtract a step with one guard bit, saturating to [0, 2^DUTY_W-1]
  function automatic logic [DUTY_W-1:0] sat_step(
    input logic [DUTY_W-1:0] val,
    input logic [DUTY_W-1:0] step,
    input logic              dec
  );
    logic [DUTY_W:0] w_res;
    if (dec) begin
      w_res    = {1'b0, val} - {1'b0, step};
      sat_step = w_res[DUTY_W] ? '0 : w_res[DUTY_W-1:0];
    end else begin
      w_res    = {1'b0, val} + {1'b0, step};
      sat_step = w_res[DUTY_W] ? '1 : w_res[DUTY_W-1:0];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/dpwm_frame_tick.sv
`default_nettype none
// ============================================================================
// Module   : dpwm_frame_tick
// Purpose  : Free-running frame counter; tick is high for one clk in every
//            FRAME_CLKS, on the cycle the counter wraps.
// Revision : 1.0  initial release
// ============================================================================
module dpwm_frame_tick #(
  parameter int FRAME_CLKS = 128
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int              CNT_W  = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(FRAME_CLKS - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count 0..FRAME_CLKS-1 and wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_cnt == c_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/dpwm_duty_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dpwm_duty_sequencer
// Purpose  : Sequences the duty command for the dither + deadtime DPWM path:
//            soft-start, frame-synchronous slew-limited updates, graceful
//            shutdown and latched fault shutdown.
//            Optional macro DUTY_CLAMP_EN: clamp accepted targets to
//            [DUTY_MIN, DUTY_MAX] and start soft-start from DUTY_MIN.
// Revision : 1.0  initial release
// ============================================================================
module dpwm_duty_sequencer
  import dpwm_pkg::*;
#(
  parameter int FRAME_CLKS = 128,
  parameter int SS_STEP    = 4,
  parameter int RAMP_STEP  = 16
`ifdef DUTY_CLAMP_EN
  ,
  parameter int DUTY_MIN   = 8,
  parameter int DUTY_MAX   = 1000
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              fault,
  input  logic              fault_clr,
  input  logic [DUTY_W-1:0] target_duty,
  input  logic              target_vld,
  output logic              target_rdy,
  output logic [DUTY_W-1:0] duty_cmd,
  output logic              gate_en,
  output logic [2:0]        state
);

  localparam logic [DUTY_W-1:0] c_ss_step   = DUTY_W'(SS_STEP);
  localparam logic [DUTY_W-1:0] c_ramp_step = DUTY_W'(RAMP_STEP);
`ifdef DUTY_CLAMP_EN
  localparam logic [DUTY_W-1:0] c_duty_min  = DUTY_W'(DUTY_MIN);
  localparam logic [DUTY_W-1:0] c_duty_max  = DUTY_W'(DUTY_MAX);
`endif

  logic              w_tick;
  logic              w_accept;
  logic [DUTY_W-1:0] w_target_in;
  logic [DUTY_W-1:0] w_ss_sum;
  logic [DUTY_W-1:0] w_ss_next;
  logic [DUTY_W-1:0] w_run_next;
  logic [DUTY_W-1:0] w_dn_next;

  logic [DUTY_W-1:0] r_duty;
  logic [DUTY_W-1:0] r_target;
  logic              r_gate_en;
  logic              r_target_rdy;
  state_t            r_state;

  dpwm_frame_tick #(
    .FRAME_CLKS (FRAME_CLKS)
  ) u_frame_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  assign w_accept = target_vld && r_target_rdy;

  // Value loaded into the target register on acceptance
  always_comb begin
    w_target_in = target_duty;
`ifdef DUTY_CLAMP_EN
    if (target_duty < c_duty_min) begin
      w_target_in = c_duty_min;
    end else if (target_duty > c_duty_max) begin
      w_target_in = c_duty_max;
    end
`endif
  end

  // Soft-start step: add SS_STEP, then cap at the target
  always_comb begin
    w_ss_sum  = sat_step(r_duty, c_ss_step, 1'b0);
    w_ss_next = (w_ss_sum > r_target) ? r_target : w_ss_sum;
`ifdef DUTY_CLAMP_EN
    // Jump straight to the floor when it lies below the target
    if ((r_duty < c_duty_min) && (c_duty_min <= r_target)) begin
      w_ss_next = c_duty_min;
    end
`endif
  end

  // Run slew: move toward the target by at most RAMP_STEP, landing exactly on it
  always_comb begin
    w_run_next = r_duty;
    if (r_target > r_duty) begin
      w_run_next = ((r_target - r_duty) <= c_ramp_step) ? r_target
                                                        : sat_step(r_duty, c_ramp_step, 1'b0);
    end else if (r_target < r_duty) begin
      w_run_next = ((r_duty - r_target) <= c_ramp_step) ? r_target
                                                        : sat_step(r_duty, c_ramp_step, 1'b1);
    end
  end

  assign w_dn_next = sat_step(r_duty, c_ramp_step, 1'b1);

  // Target register: loads on every vld&&rdy handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target <= '0;
    end else if (w_accept) begin
      r_target <= w_target_in;
    end
  end

  // Sequencer FSM with registered duty, gate enable and ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_duty       <= '0;
      r_gate_en    <= 1'b0;
      r_target_rdy <= 1'b0;
    end else if (fault) begin
      // Fault overrides everything and acts without waiting for a tick
      r_state      <= ST_FAULT;
      r_duty       <= '0;
      r_gate_en    <= 1'b0;
      r_target_rdy <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_duty       <= '0;
          r_gate_en    <= 1'b0;
          r_target_rdy <= 1'b1;
          if (enable) begin
            r_state   <= ST_SOFTSTART;
            r_gate_en <= 1'b1;
          end
        end

        ST_SOFTSTART: begin
          if (!enable) begin
            r_state      <= ST_SHUTDOWN;
            r_target_rdy <= 1'b0;
          end else if (w_tick) begin
            r_duty <= w_ss_next;
            if (w_ss_next == r_target) begin
              r_state <= ST_RUN;
            end
          end
        end

        ST_RUN: begin
          if (!enable) begin
            r_state      <= ST_SHUTDOWN;
            r_target_rdy <= 1'b0;
          end else if (w_tick) begin
            r_duty <= w_run_next;
          end
        end

        ST_SHUTDOWN: begin
          if (enable) begin
            // Resume soft-start from wherever the ramp-down has reached
            r_state      <= ST_SOFTSTART;
            r_target_rdy <= 1'b1;
          end else if (w_tick) begin
            r_duty <= w_dn_next;
            if (w_dn_next == '0) begin
              r_state      <= ST_IDLE;
              r_gate_en    <= 1'b0;
              r_target_rdy <= 1'b1;
            end
          end
        end

        ST_FAULT: begin
          r_duty       <= '0;
          r_gate_en    <= 1'b0;
          r_target_rdy <= 1'b0;
          if (fault_clr) begin
            r_state      <= ST_IDLE;
            r_target_rdy <= 1'b1;
          end
        end

        default: begin
          r_state      <= ST_IDLE;
          r_duty       <= '0;
          r_gate_en    <= 1'b0;
          r_target_rdy <= 1'b0;
        end
      endcase
    end
  end

  assign duty_cmd   = r_duty;
  assign gate_en    = r_gate_en;
  assign target_rdy = r_target_rdy;
  assign state      = r_state;

endmodule
`default_nettype wire
